cache_controller: RTL and testbench

Sequencing controller for the direct-mapped cache: owns the valid-bit RAM, tag RAM and data RAM index/write strobes and the main-memory handshake. It walks the valid RAM to invalidate all 1024 lines after reset or on a flush request, services CPU reads (hit from cache, miss with line fill) and services CPU writes (write-through, update on hit, no allocate on miss). It sits between the CPU port and the cache RAMs / memory bus.

---
 rtl/cache_pkg.sv | 31 +++
 rtl/flush_sequencer.sv | 39 +++
 rtl/cache_controller.sv | 192 +++++++++++++++++++
 tb/tb_cache_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache controller: geometry, address split, state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cache_pkg;

  localparam int ADDRWIDTH = 16;
  localparam int DATAWIDTH = 32;
  localparam int CACHESIZE = 1024;

  // Address split: tag above the line index, no offset bits (one word per line).
  localparam int INDEX_LSB  = 0;
  localparam int INDEX_MSB  = 9;
  localparam int TAG_LSB    = 10;
  localparam int TAG_MSB    = 15;
  localparam int INDEXWIDTH = INDEX_MSB - INDEX_LSB + 1;
  localparam int TAGWIDTH   = TAG_MSB - TAG_LSB + 1;

  typedef enum logic [2:0] {
    FLUSH  = 3'd0,
    IDLE   = 3'd1,
    LOOKUP = 3'd2,
    MEMRD  = 3'd3,
    MEMWR  = 3'd4
  } state_t;

  localparam logic READ    = 1'b1;
  localparam logic WRITE   = 1'b0;
  localparam logic PRESENT = 1'b1;
  localparam logic ABSENT  = 1'b0;

endpackage

// File: rtl/flush_sequencer.sv
// Line counter that walks every cache index once for an invalidate-all.
// Latency: one index per cycle while run is high; done flags the last index.
// Backpressure: none; the walk cannot be stalled, only restarted by start or Reset.
//
// Ports: Clk, Reset (async, active-low), start (clear counter), run (advance),
//        index (current line), done (run && index is the last line).
module flush_sequencer
  import cache_pkg::*;
#(
  parameter int LINES = CACHESIZE
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     start,
  input  logic                     run,
  output logic [$clog2(LINES)-1:0] index,
  output logic                     done
);

  localparam int IW = $clog2(LINES);

  logic last;

  assign last = (index == IW'(LINES - 1));
  assign done = run && last;

  // The counter wraps to 0 on the last line, so it is already cleared for the
  // next walk; start only matters if a walk is ever cut short.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      index <= '0;
    end else if (start) begin
      index <= '0;
    end else if (run) begin
      index <= last ? '0 : index + IW'(1);
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Sequencer for a direct-mapped write-through cache: flush walk, read hit/miss with fill, write-through.
// Latency: read hit 2 cycles from CpuReq to CpuReady; miss/write 1 cycle after MemAck.
// Backpressure: CpuReq is dropped while Busy; Flush while Busy is remembered and run afterwards.
//
// Ports: CPU side (CpuReq/CpuRead/CpuAddr/CpuWData -> CpuRData/CpuReady, Busy, Flush),
//        RAM side (RamIndex, Valid/Tag/Data write strobes and data, one-cycle-latency read data),
//        memory side (MemReq/MemRead/MemAddr/MemWData -> MemRData/MemAck).
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDRWIDTH = cache_pkg::ADDRWIDTH,
  parameter int DATAWIDTH = cache_pkg::DATAWIDTH,
  parameter int CACHESIZE = cache_pkg::CACHESIZE
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  CpuReq,
  input  logic                  CpuRead,
  input  logic [ADDRWIDTH-1:0]  CpuAddr,
  input  logic [DATAWIDTH-1:0]  CpuWData,
  input  logic                  Flush,
  output logic [DATAWIDTH-1:0]  CpuRData,
  output logic                  CpuReady,
  output logic                  Busy,
  output logic [INDEXWIDTH-1:0] RamIndex,
  output logic                  ValidWr,
  output logic                  ValidIn,
  input  logic                  ValidOut,
  output logic                  TagWr,
  output logic [TAGWIDTH-1:0]   TagIn,
  input  logic [TAGWIDTH-1:0]   TagOut,
  output logic                  DataWr,
  output logic [DATAWIDTH-1:0]  DataIn,
  input  logic [DATAWIDTH-1:0]  DataOut,
  output logic                  MemReq,
  output logic                  MemRead,
  output logic [ADDRWIDTH-1:0]  MemAddr,
  output logic [DATAWIDTH-1:0]  MemWData,
  input  logic [DATAWIDTH-1:0]  MemRData,
  input  logic                  MemAck
);

  state_t                 state;
  logic [ADDRWIDTH-1:0]   req_addr;
  logic                   req_read;
  logic [DATAWIDTH-1:0]   req_wdata;
  logic                   flush_pend;
  logic [INDEXWIDTH-1:0]  flush_index;
  logic                   flush_done;
  logic                   flush_go;
  logic                   hit;
  logic [TAGWIDTH-1:0]    req_tag;
  logic [INDEXWIDTH-1:0]  req_index;

  assign req_tag   = req_addr[TAG_MSB:TAG_LSB];
  assign req_index = req_addr[INDEX_MSB:INDEX_LSB];
  // RAM read data belongs to the index presented in the IDLE cycle, i.e. the latched request.
  assign hit       = ValidOut && (TagOut == req_tag);
  assign flush_go  = (state == IDLE) && (Flush || flush_pend);
  assign Busy      = (state != IDLE);

  flush_sequencer #(
    .LINES (CACHESIZE)
  ) u_flush (
    .Clk   (Clk),
    .Reset (Reset),
    .start (flush_go),
    .run   (state == FLUSH),
    .index (flush_index),
    .done  (flush_done)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= FLUSH;
      req_addr   <= '0;
      req_read   <= 1'b0;
      req_wdata  <= '0;
      flush_pend <= 1'b0;
      CpuReady   <= 1'b0;
      CpuRData   <= '0;
    end else begin
      CpuReady <= 1'b0;
      // A flush arriving during a CPU transaction waits for it to finish. One
      // arriving during a walk is already covered: nothing refills lines mid-walk.
      if (Flush && (state == LOOKUP || state == MEMRD || state == MEMWR)) begin
        flush_pend <= 1'b1;
      end
      case (state)
        FLUSH: begin
          if (flush_done) state <= IDLE;
        end
        IDLE: begin
          if (flush_go) begin
            flush_pend <= 1'b0;
            state      <= FLUSH;
          end else if (CpuReq) begin
            req_addr  <= CpuAddr;
            req_read  <= CpuRead;
            req_wdata <= CpuWData;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (req_read == READ) begin
            if (hit) begin
              CpuRData <= DataOut;
              CpuReady <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= MEMRD;
            end
          end else begin
            state <= MEMWR;
          end
        end
        MEMRD: begin
          if (MemAck) begin
            CpuRData <= MemRData;
            CpuReady <= 1'b1;
            state    <= IDLE;
          end
        end
        MEMWR: begin
          if (MemAck) begin
            CpuReady <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= FLUSH;
      endcase
    end
  end

  // RAM and memory strobes decode straight from state so that an asynchronous
  // reset drops MemReq immediately and the index is ready a cycle before LOOKUP.
  always_comb begin
    RamIndex = '0;
    ValidWr  = 1'b0;
    ValidIn  = ABSENT;
    TagWr    = 1'b0;
    TagIn    = '0;
    DataWr   = 1'b0;
    DataIn   = '0;
    MemReq   = 1'b0;
    MemRead  = 1'b0;
    MemAddr  = '0;
    MemWData = '0;
    case (state)
      FLUSH: begin
        RamIndex = flush_index;
        ValidWr  = 1'b1;
        ValidIn  = ABSENT;
      end
      IDLE: begin
        RamIndex = CpuAddr[INDEX_MSB:INDEX_LSB];
      end
      LOOKUP: begin
        RamIndex = req_index;
        if (req_read == WRITE && hit) begin
          DataWr = 1'b1;
          DataIn = req_wdata;
        end
      end
      MEMRD: begin
        RamIndex = req_index;
        MemReq   = 1'b1;
        MemRead  = READ;
        MemAddr  = req_addr;
        if (MemAck) begin
          DataWr  = 1'b1;
          DataIn  = MemRData;
          TagWr   = 1'b1;
          TagIn   = req_tag;
          ValidWr = 1'b1;
          ValidIn = PRESENT;
        end
      end
      MEMWR: begin
        RamIndex = req_index;
        MemReq   = 1'b1;
        MemRead  = WRITE;
        MemAddr  = req_addr;
        MemWData = req_wdata;
      end
      default: begin
        RamIndex = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: RAM models with one-cycle read latency,
// a table of CPU transactions with hand-computed results, and hand-written
// sequences for reset, flush walks, flush-while-busy and reset mid-transaction.
module tb_cache_controller;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        CpuReq = 1'b0;
  logic        CpuRead = 1'b0;
  logic [15:0] CpuAddr = '0;
  logic [31:0] CpuWData = '0;
  logic        Flush = 1'b0;
  logic [31:0] CpuRData;
  logic        CpuReady;
  logic        Busy;
  logic [9:0]  RamIndex;
  logic        ValidWr, ValidIn;
  logic        ValidOut = 1'b0;
  logic        TagWr;
  logic [5:0]  TagIn;
  logic [5:0]  TagOut = '0;
  logic        DataWr;
  logic [31:0] DataIn;
  logic [31:0] DataOut = '0;
  logic        MemReq, MemRead;
  logic [15:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData = '0;
  logic        MemAck = 1'b0;

  cache_controller dut (
    .Clk(Clk), .Reset(Reset), .CpuReq(CpuReq), .CpuRead(CpuRead), .CpuAddr(CpuAddr),
    .CpuWData(CpuWData), .Flush(Flush), .CpuRData(CpuRData), .CpuReady(CpuReady),
    .Busy(Busy), .RamIndex(RamIndex), .ValidWr(ValidWr), .ValidIn(ValidIn),
    .ValidOut(ValidOut), .TagWr(TagWr), .TagIn(TagIn), .TagOut(TagOut),
    .DataWr(DataWr), .DataIn(DataIn), .DataOut(DataOut), .MemReq(MemReq),
    .MemRead(MemRead), .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData),
    .MemAck(MemAck)
  );

  always #5 Clk = ~Clk;

  // Valid/tag/data RAMs, registered read of the presented index.
  logic        vram [1024];
  logic [5:0]  tram [1024];
  logic [31:0] dram [1024];

  always @(posedge Clk) begin
    ValidOut <= vram[RamIndex];
    TagOut   <= tram[RamIndex];
    DataOut  <= dram[RamIndex];
    if (ValidWr) vram[RamIndex] <= ValidIn;
    if (TagWr)   tram[RamIndex] <= TagIn;
    if (DataWr)  dram[RamIndex] <= DataIn;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          rd;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          ack_at;     // MemAck in this MemReq cycle (1 = first)
    logic [31:0] mdata;
    bit          hit;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          ready_cyc;
    logic [31:0] rdata;
    int          memreq_first;
    logic        memread;
    logic [15:0] memaddr;
    logic [31:0] memwdata;
    int          lk_datawr;
    logic [31:0] lk_datain;
    int          fills;
    logic [9:0]  fill_idx;
    logic [5:0]  fill_tag;
    logic [31:0] fill_data;
    logic        fill_valid;
    int          stray_wr;
  } res_t;

  // Runs one CPU transaction; cycle 0 is the CpuReq cycle. Inputs change at
  // negedge, outputs are sampled 1 time unit later.
  task automatic run_txn(input vec_t v, input int flush_at, output res_t r);
    int memcyc = 0;
    r = '{default: 0};
    r.ready_cyc    = -1;
    r.memreq_first = -1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge Clk);
      CpuReq   = (cyc == 0);
      CpuRead  = v.rd;
      CpuAddr  = v.addr;
      CpuWData = v.wdata;
      Flush    = (cyc == flush_at);
      MemAck   = 1'b0;
      if (MemReq) begin
        memcyc++;
        if (memcyc == v.ack_at) begin
          MemAck   = 1'b1;
          MemRData = v.mdata;
        end
      end
      #1;
      if (MemReq && r.memreq_first < 0) begin
        r.memreq_first = cyc;
        r.memread      = MemRead;
        r.memaddr      = MemAddr;
        r.memwdata     = MemWData;
      end
      if (MemAck && DataWr && TagWr && ValidWr) begin
        r.fills++;
        r.fill_idx   = RamIndex;
        r.fill_tag   = TagIn;
        r.fill_data  = DataIn;
        r.fill_valid = ValidIn;
      end else if (cyc == 1 && DataWr && !TagWr && !ValidWr) begin
        r.lk_datawr++;
        r.lk_datain = DataIn;
      end else if (DataWr || TagWr || ValidWr) begin
        r.stray_wr++;
      end
      if (CpuReady) begin
        r.ready_cyc = cyc;
        r.rdata     = CpuRData;
        break;
      end
    end
    Flush  = 1'b0;
    MemAck = 1'b0;
  endtask

  task automatic check_txn(input string nm, input vec_t v, input res_t r);
    bit rd_hit = v.rd && v.hit;
    check({nm, " ready_cycle"}, 64'(r.ready_cyc), rd_hit ? 64'd2 : 64'(2 + v.ack_at));
    check({nm, " memreq_seen"}, 64'(r.memreq_first >= 0), 64'(!rd_hit));
    if (!rd_hit) begin
      check({nm, " memreq_cycle"}, 64'(r.memreq_first), 64'd2);
      check({nm, " memread"}, 64'(r.memread), 64'(v.rd));
      check({nm, " memaddr"}, 64'(r.memaddr), 64'(v.addr));
      if (!v.rd) check({nm, " memwdata"}, 64'(r.memwdata), 64'(v.wdata));
    end
    check({nm, " lookup_datawr"}, 64'(r.lk_datawr), 64'(!v.rd && v.hit));
    if (!v.rd && v.hit) check({nm, " lookup_datain"}, 64'(r.lk_datain), 64'(v.wdata));
    check({nm, " fills"}, 64'(r.fills), 64'(v.rd && !v.hit));
    if (v.rd && !v.hit) begin
      check({nm, " fill_idx"}, 64'(r.fill_idx), 64'(v.addr[9:0]));
      check({nm, " fill_tag"}, 64'(r.fill_tag), 64'(v.addr[15:10]));
      check({nm, " fill_data"}, 64'(r.fill_data), 64'(v.mdata));
      check({nm, " fill_valid"}, 64'(r.fill_valid), 64'd1);
    end
    check({nm, " stray_writes"}, 64'(r.stray_wr), 64'd0);
    if (v.rd) check({nm, " rdata"}, 64'(r.rdata), 64'(v.exp_rdata));
  endtask

  // Called at a sample point in the first cycle expected to be a flush cycle.
  task automatic check_flush(input string nm);
    int n = 0;
    int bad_idx = 0;
    int bad_vin = 0;
    int other = 0;
    for (int g = 0; g < 1200 && Busy; g++) begin
      if (ValidWr) begin
        if (RamIndex !== 10'(n)) bad_idx++;
        if (ValidIn !== 1'b0) bad_vin++;
        n++;
      end
      if (DataWr || TagWr || MemReq || CpuReady) other++;
      @(negedge Clk);
      #1;
    end
    check({nm, " validwr_cycles"}, 64'(n), 64'd1024);
    check({nm, " index_sequence_errs"}, 64'(bad_idx), 64'd0);
    check({nm, " validin_errs"}, 64'(bad_vin), 64'd0);
    check({nm, " other_activity"}, 64'(other), 64'd0);
    check({nm, " busy_after"}, 64'(Busy), 64'd0);
  endtask

  vec_t vecs[11];
  vec_t v;
  res_t r;

  initial begin
    // rd, addr, wdata, ack_at, mdata, hit, exp_rdata
    vecs[0]  = '{1'b1, 16'h0404, 32'h0, 3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 16'h0404, 32'h0, 0, 32'h0,        1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 16'h0804, 32'h0, 1, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D};
    vecs[3]  = '{1'b1, 16'h0804, 32'h0, 0, 32'h0,        1'b1, 32'hCAFEF00D};
    vecs[4]  = '{1'b1, 16'h0404, 32'h0, 2, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 16'h0404, 32'h12345678, 2, 32'h0, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 16'h0404, 32'h0, 0, 32'h0,        1'b1, 32'h12345678};
    vecs[7]  = '{1'b0, 16'h1234, 32'hA5A5A5A5, 1, 32'h0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 16'h1234, 32'h0, 1, 32'h55AA55AA, 1'b0, 32'h55AA55AA};
    vecs[9]  = '{1'b0, 16'h0804, 32'h0BADF00D, 1, 32'h0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 16'h0404, 32'h0, 0, 32'h0,        1'b1, 32'h12345678};

    // Reset state
    repeat (3) @(negedge Clk);
    #1;
    check("rst busy", 64'(Busy), 64'd1);
    check("rst validwr", 64'(ValidWr), 64'd1);
    check("rst validin", 64'(ValidIn), 64'd0);
    check("rst ramindex", 64'(RamIndex), 64'd0);
    check("rst memreq", 64'(MemReq), 64'd0);
    check("rst cpuready", 64'(CpuReady), 64'd0);
    check("rst cpurdata", 64'(CpuRData), 64'd0);
    check("rst datawr_tagwr", 64'({DataWr, TagWr}), 64'd0);

    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check_flush("init_flush");

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i], -1, r);
      check_txn($sformatf("vec%0d", i), vecs[i], r);
    end

    // Flush during MEMRD: transaction completes, then a full walk.
    v = '{1'b1, 16'h0C04, 32'h0, 3, 32'h600DF00D, 1'b0, 32'h600DF00D};
    run_txn(v, 3, r);
    check_txn("flush_in_memrd", v, r);
    @(negedge Clk);
    #1;
    check("pend_flush busy", 64'(Busy), 64'd1);
    check_flush("pend_flush");
    v = '{1'b1, 16'h0404, 32'h0, 1, 32'h11112222, 1'b0, 32'h11112222};
    run_txn(v, -1, r);
    check_txn("post_flush_read", v, r);

    // Reset with MemReq high.
    @(negedge Clk);
    CpuReq = 1'b1; CpuRead = 1'b1; CpuAddr = 16'h2C04;
    @(negedge Clk);
    CpuReq = 1'b0;
    @(negedge Clk);
    #1;
    check("mid memreq_before", 64'(MemReq), 64'd1);
    #2;
    Reset = 1'b0;
    #1;
    check("mid memreq_after", 64'(MemReq), 64'd0);
    check("mid ramindex", 64'(RamIndex), 64'd0);
    check("mid validwr", 64'(ValidWr), 64'd1);
    check("mid busy", 64'(Busy), 64'd1);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check_flush("rst_flush");
    v = '{1'b1, 16'h0804, 32'h0, 2, 32'h77778888, 1'b0, 32'h77778888};
    run_txn(v, -1, r);
    check_txn("post_reset_read", v, r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
